// File: rtl/descram.sv
// ---------------------------------------------------------------------------
// descram -- self-synchronising multiplicative descrambler
//
// Receive-side partner of the parallel scrambler. It uses the same polynomial
// and the same bit ordering: the MSB of each word is the earliest bit in time.
// Each accepted DW-bit line word is descrambled against the last PP received
// line bits. The result is registered.
// A word-count FSM raises Sync_o once the history holds only genuine line
// bits. A PRBS checker counts non-zero descrambled bits, which is useful when
// the far-end scrambler is fed all-zero data.
//
// Parameters:
//   DW    data word width (>=1)
//   PP    polynomial degree / history length
//   SI    history reset value
//   POLY  polynomial, bit k (1..PP) set = tap at delay k
//   CW    error counter width (>=2)
//
// Ports:
//   Ck        clock
//   Rs        asynchronous reset, active high
//   CE        clock enable; with CE low all state holds except Vld_o
//   Dsc_En    word accept strobe, qualified by CE
//   Dat_i     scrambled line word, bit DW-1 earliest
//   Chk_En    enable the PRBS zero-check for the accepted word
//   Err_Clr   synchronous clear of Err_Cnt / Err_Flag, qualified by CE
//   Dat_o     descrambled word, one cycle after accept
//   Vld_o     Dat_o was updated on the last edge
//   Sync_o    history holds only received line bits
//   Err_Cnt   saturating count of errored bits
//   Err_Flag  sticky error indicator
// ---------------------------------------------------------------------------
module descram #(
    parameter int            DW   = 62,
    parameter int            PP   = 58,
    parameter logic [PP-1:0] SI   = 58'h3ffffffffffffff,
    parameter logic [PP:0]   POLY = 59'h400008000000001,
    parameter int            CW   = 16
) (
    input  logic          Ck,
    input  logic          Rs,
    input  logic          CE,
    input  logic          Dsc_En,
    input  logic [DW-1:0] Dat_i,
    input  logic          Chk_En,
    input  logic          Err_Clr,
    output logic [DW-1:0] Dat_o,
    output logic          Vld_o,
    output logic          Sync_o,
    output logic [CW-1:0] Err_Cnt,
    output logic          Err_Flag
);

    // Number of accepted words needed to flush the reset value out of history
    localparam int NW  = (PP + DW - 1) / DW;
    localparam int NCW = $clog2(NW + 1);
    // Width of a per-word popcount, and of the non-wrapping error sum
    localparam int PCW = $clog2(DW + 1);
    localparam int SW  = ((CW > PCW) ? CW : PCW) + 1;
    localparam logic [SW-1:0] CNT_MAX = {{(SW-CW){1'b0}}, {CW{1'b1}}};

    typedef enum logic {
        UNSYNC,
        SYNC
    } sync_state_t;

    sync_state_t     state;
    logic [NCW-1:0]  word_cnt;
    logic [PP-1:0]   hist;
    logic            chk_pend;
    logic            accept;

    logic [PP+DW-1:0] line;
    logic [DW-1:0]    desc;
    logic [PCW-1:0]   pop_cnt;
    logic [SW-1:0]    err_sum;
    logic [CW-1:0]    sat_cnt;

    assign accept = CE & Dsc_En;

    // The history and the new word form one contiguous line stream. A higher
    // index is an older bit, so line[i] is a bit of the current word and
    // line[i+k] is the line bit k positions earlier in time. The same
    // indexing works across the word/history boundary. The recursion only
    // ever uses received bits, so every output bit is a flat XOR of inputs
    // with no chain through earlier outputs.
    assign line = {hist, Dat_i};

    always_comb begin
        desc = '0;
        for (int i = 0; i < DW; i++) begin
            desc[i] = line[i];
            for (int k = 1; k <= PP; k++) begin
                if (POLY[k]) begin
                    desc[i] = desc[i] ^ line[i+k];
                end
            end
        end
    end

    // Errored-bit count of the word currently shown on Dat_o
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < DW; i++) begin
            pop_cnt = pop_cnt + PCW'(Dat_o[i]);
        end
    end

    // The sum carries one spare bit so it cannot wrap before saturation
    assign err_sum = SW'(Err_Cnt) + SW'(pop_cnt);
    assign sat_cnt = (err_sum > CNT_MAX) ? {CW{1'b1}} : err_sum[CW-1:0];

    // Sync FSM: count accepts until NW words have passed, then stay in sync
    // until reset. Gaps in Dsc_En do not matter, because the history only
    // moves on an accept.
    always_ff @(posedge Ck or posedge Rs) begin
        if (Rs) begin
            state    <= UNSYNC;
            word_cnt <= '0;
            Sync_o   <= 1'b0;
        end else begin
            case (state)
                UNSYNC: begin
                    if (accept) begin
                        word_cnt <= word_cnt + NCW'(1);
                        if (word_cnt == NCW'(NW - 1)) begin
                            state  <= SYNC;
                            Sync_o <= 1'b1;
                        end
                    end
                end
                SYNC: begin
                    Sync_o <= 1'b1;
                end
                default: begin
                    state  <= UNSYNC;
                    Sync_o <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: on an accept, the history takes the newest PP received bits
    // (never the descrambled output) and the descrambled word is registered.
    // chk_pend remembers whether the word now going to Dat_o must be
    // checked. That decision uses Sync_o as it was when the word arrived.
    always_ff @(posedge Ck or posedge Rs) begin
        if (Rs) begin
            hist     <= SI;
            Dat_o    <= '0;
            Vld_o    <= 1'b0;
            chk_pend <= 1'b0;
        end else begin
            Vld_o <= accept;
            if (CE) begin
                chk_pend <= Dsc_En & Sync_o & Chk_En;
            end
            if (accept) begin
                hist  <= line[PP-1:0];
                Dat_o <= desc;
            end
        end
    end

    // Error accounting runs one edge after the word is shown on Dat_o. A
    // clear wins over a same-cycle increment, and that word's errors are
    // dropped.
    always_ff @(posedge Ck or posedge Rs) begin
        if (Rs) begin
            Err_Cnt  <= '0;
            Err_Flag <= 1'b0;
        end else if (CE) begin
            if (Err_Clr) begin
                Err_Cnt  <= '0;
                Err_Flag <= 1'b0;
            end else if (chk_pend) begin
                Err_Cnt  <= sat_cnt;
                Err_Flag <= Err_Flag | (pop_cnt != '0);
            end
        end
    end

endmodule

// File: tb/tb_descram.sv
// ---------------------------------------------------------------------------
// tb_descram -- self-checking bench for descram
//
// Instance 0 uses the default parameters (DW=62, CW=16).
// Instance 1 uses DW=8, CW=4 (NW=8), for sync acquisition and saturation.
// The reference model works bit-serially on the line stream. A serial
// scrambler model produces loopback traffic.
// ---------------------------------------------------------------------------
module tb_descram;

    localparam int           PP    = 58;
    localparam logic [58:0]  POLY  = 59'h400008000000001;
    localparam logic [57:0]  SI    = 58'h3ffffffffffffff;
    localparam logic [57:0]  TX_SI = {29{2'b01}};

    logic Ck = 1'b0;
    always #5 Ck = ~Ck;

    // instance 0 (defaults)
    logic        a_rs, a_ce, a_en, a_chk, a_clr;
    logic [61:0] a_din, a_dout;
    logic        a_vld, a_sync, a_flag;
    logic [15:0] a_cnt;

    // instance 1 (DW=8, CW=4)
    logic        b_rs, b_ce, b_en, b_chk, b_clr;
    logic [7:0]  b_din, b_dout;
    logic        b_vld, b_sync, b_flag;
    logic [3:0]  b_cnt;

    descram dut_a (
        .Ck(Ck), .Rs(a_rs), .CE(a_ce), .Dsc_En(a_en), .Dat_i(a_din),
        .Chk_En(a_chk), .Err_Clr(a_clr), .Dat_o(a_dout), .Vld_o(a_vld),
        .Sync_o(a_sync), .Err_Cnt(a_cnt), .Err_Flag(a_flag)
    );

    descram #(.DW(8), .CW(4)) dut_b (
        .Ck(Ck), .Rs(b_rs), .CE(b_ce), .Dsc_En(b_en), .Dat_i(b_din),
        .Chk_En(b_chk), .Err_Clr(b_clr), .Dat_o(b_dout), .Vld_o(b_vld),
        .Sync_o(b_sync), .Err_Cnt(b_cnt), .Err_Flag(b_flag)
    );

    int error_count = 0;
    int check_count = 0;

    // Reference model state per instance
    int          dw_of  [2] = '{62, 8};
    int          nw_of  [2] = '{1, 8};
    int          max_of [2] = '{65535, 15};
    logic [57:0] m_hist [2];
    logic [61:0] m_dout [2];
    int          m_cnt  [2];
    int          m_acc  [2];
    logic        m_flag [2];
    logic        m_sync [2];
    logic        m_pend [2];
    logic        m_vld  [2];

    // Serial descramble: d(n) = s(n) ^ XOR of the tapped earlier line bits
    function automatic logic [61:0] model_descram(input logic [57:0] hist_in,
                                                  input logic [61:0] word,
                                                  input int dw,
                                                  output logic [57:0] hist_out);
        logic [57:0] h;
        logic [61:0] res;
        logic        bit_s;
        logic        bit_d;
        h   = hist_in;
        res = '0;
        for (int b = dw - 1; b >= 0; b--) begin
            bit_s = word[b];
            bit_d = bit_s;
            for (int k = 1; k <= PP; k++) begin
                if (POLY[k]) bit_d = bit_d ^ h[k-1];
            end
            res[b] = bit_d;
            h = {h[56:0], bit_s};
        end
        hist_out = h;
        return res;
    endfunction

    // Serial scramble: s(n) = x(n) ^ XOR of the tapped earlier line bits
    function automatic logic [61:0] model_scram(input logic [57:0] hist_in,
                                                input logic [61:0] data,
                                                input int dw,
                                                output logic [57:0] hist_out);
        logic [57:0] h;
        logic [61:0] res;
        logic        bit_s;
        h   = hist_in;
        res = '0;
        for (int b = dw - 1; b >= 0; b--) begin
            bit_s = data[b];
            for (int k = 1; k <= PP; k++) begin
                if (POLY[k]) bit_s = bit_s ^ h[k-1];
            end
            res[b] = bit_s;
            h = {h[56:0], bit_s};
        end
        hist_out = h;
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input int i, input string tag);
        if (i == 0) begin
            checkOutput({tag, "_a_vld"},  64'(a_vld),  64'(m_vld[0]));
            checkOutput({tag, "_a_sync"}, 64'(a_sync), 64'(m_sync[0]));
            checkOutput({tag, "_a_dout"}, 64'(a_dout), 64'(m_dout[0]));
            checkOutput({tag, "_a_cnt"},  64'(a_cnt),  64'(m_cnt[0]));
            checkOutput({tag, "_a_flag"}, 64'(a_flag), 64'(m_flag[0]));
        end else begin
            checkOutput({tag, "_b_vld"},  64'(b_vld),  64'(m_vld[1]));
            checkOutput({tag, "_b_sync"}, 64'(b_sync), 64'(m_sync[1]));
            checkOutput({tag, "_b_dout"}, 64'(b_dout), 64'(m_dout[1]));
            checkOutput({tag, "_b_cnt"},  64'(b_cnt),  64'(m_cnt[1]));
            checkOutput({tag, "_b_flag"}, 64'(b_flag), 64'(m_flag[1]));
        end
    endtask

    task automatic modelReset(input int i);
        m_hist[i] = SI;
        m_dout[i] = '0;
        m_cnt[i]  = 0;
        m_acc[i]  = 0;
        m_flag[i] = 1'b0;
        m_sync[i] = 1'b0;
        m_pend[i] = 1'b0;
        m_vld[i]  = 1'b0;
    endtask

    // Drive one cycle (called at posedge+1), advance the model across the
    // edge, then compare everything
    task automatic applyStimulus(input int i, input logic ce, input logic en,
                                 input logic [61:0] din, input logic chk,
                                 input logic clr, input string tag);
        logic [57:0] hn;
        int          e;
        if (i == 0) begin
            a_ce = ce; a_en = en; a_din = din; a_chk = chk; a_clr = clr;
        end else begin
            b_ce = ce; b_en = en; b_din = din[7:0]; b_chk = chk; b_clr = clr;
        end
        @(posedge Ck);
        #1;
        if (ce) begin
            if (clr) begin
                m_cnt[i]  = 0;
                m_flag[i] = 1'b0;
            end else if (m_pend[i]) begin
                e = $countones(m_dout[i]);
                if (e != 0) m_flag[i] = 1'b1;
                m_cnt[i] = (m_cnt[i] + e > max_of[i]) ? max_of[i] : m_cnt[i] + e;
            end
            m_pend[i] = en & m_sync[i] & chk;
            if (en) begin
                m_dout[i] = model_descram(m_hist[i], din, dw_of[i], hn);
                m_hist[i] = hn;
                m_acc[i]++;
                if (m_acc[i] >= nw_of[i]) m_sync[i] = 1'b1;
            end
        end
        m_vld[i] = ce & en;
        checkAll(i, tag);
    endtask

    // Raise reset mid-cycle, check outputs clear at once, then release it
    task automatic doReset(input int i);
        #2;
        if (i == 0) a_rs = 1'b1; else b_rs = 1'b1;
        #1;
        modelReset(i);
        checkAll(i, "rst_async");
        if (i == 0) begin
            a_ce = 0; a_en = 0; a_chk = 0; a_clr = 0;
        end else begin
            b_ce = 0; b_en = 0; b_chk = 0; b_clr = 0;
        end
        @(negedge Ck);
        if (i == 0) a_rs = 1'b0; else b_rs = 1'b0;
        @(posedge Ck);
        #1;
        checkAll(i, "rst_rel");
    endtask

    logic [57:0] tx_hist;
    logic [61:0] word;
    logic [61:0] plain;
    int          sent;
    int          cyc;
    logic        ce_r, en_r;
    logic        clr_done;

    initial begin
        a_rs = 1; b_rs = 1;
        a_ce = 0; a_en = 0; a_din = '0; a_chk = 0; a_clr = 0;
        b_ce = 0; b_en = 0; b_din = '0; b_chk = 0; b_clr = 0;
        modelReset(0);
        modelReset(1);
        @(negedge Ck);
        a_rs = 0; b_rs = 0;
        @(posedge Ck);
        #1;
        checkAll(0, "init");
        checkAll(1, "init");

        // Reset mid-operation, then idle with nothing accepted
        $display("[TB] reset behaviour");
        for (int n = 0; n < 6; n++)
            applyStimulus(0, 1, 1, {$urandom, $urandom}, 1, 0, "pre");
        doReset(0);
        for (int n = 0; n < 5; n++)
            applyStimulus(0, 1'($urandom), 0, {$urandom, $urandom}, 1, 0, "idle");

        // Loopback of zero data: sync after word 1, zero output afterwards
        $display("[TB] loopback zero data");
        tx_hist = TX_SI;
        for (int w = 1; w <= 1000; w++) begin
            word = model_scram(tx_hist, '0, 62, tx_hist);
            applyStimulus(0, 1, 1, word, 1, 0, "lb");
            checkOutput("lb_sync_hi", 64'(a_sync), 64'(1));
            if (w >= 2) checkOutput("lb_zero", 64'(a_dout), 64'(0));
        end
        applyStimulus(0, 1, 0, '0, 1, 0, "lb_flush");
        applyStimulus(0, 1, 0, '0, 1, 0, "lb_flush");
        checkOutput("lb_errcnt", 64'(a_cnt), 64'(0));
        checkOutput("lb_errflag", 64'(a_flag), 64'(0));

        // Single line bit error: three errored bits across words 20 and 21
        $display("[TB] single bit error");
        doReset(0);
        tx_hist = TX_SI;
        for (int w = 1; w <= 40; w++) begin
            word = model_scram(tx_hist, '0, 62, tx_hist);
            if (w == 20) word[10] = ~word[10];
            applyStimulus(0, 1, 1, word, 1, 0, "biterr");
            if (w >= 2)
                checkOutput("biterr_word", 64'(a_dout != '0), 64'(w == 20 || w == 21));
        end
        applyStimulus(0, 1, 0, '0, 1, 0, "biterr_flush");
        applyStimulus(0, 1, 0, '0, 1, 0, "biterr_flush");
        checkOutput("biterr_cnt", 64'(a_cnt), 64'(3));
        checkOutput("biterr_flag", 64'(a_flag), 64'(1));

        // Random accept gaps and CE-low windows; junk data when not accepted
        $display("[TB] gapped traffic");
        doReset(0);
        tx_hist = TX_SI;
        sent = 0;
        cyc  = 0;
        plain = {$urandom, $urandom};
        word = model_scram(tx_hist, plain, 62, tx_hist);
        while (sent < 200 && cyc < 5000) begin
            ce_r = ((cyc % 40) < 34);
            en_r = 1'($urandom);
            if (ce_r && en_r) begin
                applyStimulus(0, 1, 1, word, 0, 0, "gap");
                sent++;
                if (sent >= 2) checkOutput("gap_plain", 64'(a_dout), 64'(plain));
                plain = {$urandom, $urandom};
                word = model_scram(tx_hist, plain, 62, tx_hist);
            end else begin
                applyStimulus(0, ce_r, en_r, {$urandom, $urandom}, 0, 0, "gap");
            end
            if (sent >= 1) checkOutput("gap_sync_hold", 64'(a_sync), 64'(1));
            cyc++;
        end
        checkOutput("gap_budget", 64'(sent), 64'(200));

        // Saturation at 15 with random data, then clear on an errored word
        $display("[TB] saturation and clear");
        doReset(1);
        for (int n = 0; n < 60; n++)
            applyStimulus(1, 1, 1, 62'($urandom), 1, 0, "sat");
        checkOutput("sat_cnt", 64'(b_cnt), 64'(15));
        checkOutput("sat_flag", 64'(b_flag), 64'(1));
        clr_done = 1'b0;
        for (int n = 0; n < 200 && !clr_done; n++) begin
            if (m_pend[1] && $countones(m_dout[1]) != 0) begin
                applyStimulus(1, 1, 1, 62'($urandom), 1, 1, "clr");
                checkOutput("clr_cnt", 64'(b_cnt), 64'(0));
                checkOutput("clr_flag", 64'(b_flag), 64'(0));
                clr_done = 1'b1;
            end else begin
                applyStimulus(1, 1, 1, 62'($urandom), 1, 0, "clr_wait");
            end
        end
        checkOutput("clr_found", 64'(clr_done), 64'(1));

        // Narrow word: sync on the 8th accept, reacquired after a reset
        $display("[TB] narrow word sync");
        for (int pass = 0; pass < 2; pass++) begin
            doReset(1);
            if (pass == 0) tx_hist = TX_SI;
            for (int w = 1; w <= ((pass == 0) ? 100 : 30); w++) begin
                word = model_scram(tx_hist, '0, 8, tx_hist);
                applyStimulus(1, 1, 1, word, 1, 0, "nw");
                checkOutput("nw_sync", 64'(b_sync), 64'(w >= 8));
                if (w >= 9) checkOutput("nw_zero", 64'(b_dout), 64'(0));
            end
        end
        applyStimulus(1, 1, 0, '0, 1, 0, "nw_flush");
        checkOutput("nw_errcnt", 64'(b_cnt), 64'(0));

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/descram.md
Name: descram

Overview:
Self-synchronising multiplicative descrambler. It is the receive-side partner of the team's parallel scrambler, using the same polynomial and bit ordering.
- Each accepted DW-bit word is descrambled against a history of the last PP received line bits. Results are registered.
- A word-count sync FSM flags when the history is filled with genuine line data.
- A PRBS checker counts non-zero descrambled bits when the transmitter is fed all-zero data.
- Sits between the deserializer/gearbox output and block-sync/decode logic.

Parameters:
DW, 62, data word width (>=1)
SI, 58'h3ffffffffffffff, history register reset value
PP, 58, polynomial degree
POLY, 59'h400008000000001, polynomial; bit k (1..PP) set = tap at delay k (default x^58+x^39+1)
CW, 16, error counter width (>=2)

Ports:
Ck  input  1  clock
Rs  input  1  asynchronous reset, active high
CE  input  1  clock enable, active high
Dsc_En  input  1  word accept strobe, qualified by CE
Dat_i  input  DW  scrambled line word; bit DW-1 earliest in time
Chk_En  input  1  enable PRBS zero-check
Err_Clr  input  1  synchronous clear of Err_Cnt and Err_Flag, qualified by CE
Dat_o  output  DW  descrambled word, registered
Vld_o  output  1  Dat_o updated this cycle
Sync_o  output  1  history holds only received line bits
Err_Cnt  output  CW  saturating count of errored bits
Err_Flag  output  1  sticky: any error seen since reset or clear

Behaviour:
- Interface: one clock Ck; reset Rs is asynchronous and active-high.
- Reset values (Rs high, async):
  - H (PP-bit history) = SI
  - Dat_o = 0, Vld_o = 0, Sync_o = 0, Err_Cnt = 0, Err_Flag = 0
  - FSM = UNSYNC, word counter = 0
- Accept: a word is accepted on the Ck edge where CE=1 and Dsc_En=1. With CE=0, all state holds except Vld_o.
- Vld_o is sampled every Ck edge: Vld_o <= CE & Dsc_En. It is a one-cycle pulse per accepted word.
- Descramble rule, per bit. Let s be the serial line stream; MSB of a word is earliest; H[0] is the most recent prior bit and H[PP-1] the oldest.
  - d(n) = s(n) XOR (XOR over k=1..PP of POLY[k]·s(n-k)).
  - Bits inside the same word use earlier bits of that Dat_i word as history. Evaluate as one combinational chain over {H, Dat_i}.
- Latency: Dat_o holds the descramble of the word accepted on the previous edge (1 cycle).
- History update on accept:
  - DW>=PP: H <= Dat_i[PP-1:0].
  - DW<PP: H <= {H[PP-DW-1:0], Dat_i}.
  - History always takes received (scrambled) bits, never Dat_o.
- Sync FSM, with NW = ceil(PP/DW); default NW = 1:
  - UNSYNC: on each accept, counter++. When the counter reaches NW, go to SYNC. Sync_o=1 from the edge of the NW-th accept.
  - SYNC: stays until Rs. Dsc_En gaps do not drop sync.
  - Dat_o is produced in both states. Words accepted while Sync_o=0 are unreliable.
- PRBS check, on the edge after a word is presented to Dat_o:
  - The word is checked if it was accepted with Sync_o=1 and Chk_En=1 at accept time.
  - e = popcount of the descrambled word.
  - Err_Cnt <= min(Err_Cnt + e, 2^CW-1). The sum is computed wide enough that it cannot wrap.
  - Err_Flag <= Err_Flag | (e!=0).
- Err_Clr (with CE):
  - Err_Cnt <= 0, Err_Flag <= 0.
  - Err_Clr has priority over a same-cycle increment; that word's errors are discarded.
- Saturation: at 2^CW-1, Err_Cnt stays put. Err_Flag still sets.
- Rs mid-operation: immediate return to reset values. Any in-flight word is lost. Sync re-acquires after NW further accepts.
- A single line bit error at s(n) produces errors at d(n) and d(n+k) for each set POLY[k]. For the default polynomial that is 3 errored bits, possibly across two words.

Test Plan:
1. Reset: assert Rs async mid-cycle -> Dat_o=0, Vld_o=0, Sync_o=0, Err_Cnt=0, Err_Flag=0 immediately. Release and accept nothing -> all outputs hold.
2. Loopback from scrambler (same defaults, its Dat_i=0, scrambler SI=58'h155...) with Chk_En=1 -> Sync_o=1 after word 1. Dat_o=0 for every checked word over 1000 words. Err_Cnt=0, Err_Flag=0.
3. Same loopback, flip Dat_i bit 10 of word 20 -> Err_Cnt=3 total, Err_Flag=1. Dat_o differs from zero only in words 20 and 21.
4. Random Dsc_En gaps (about 50% duty) plus CE low windows -> Vld_o pulses once per accept. Output sequence is identical to the gapless run. Sync_o never drops.
5. CW=4, Dat_i random with Chk_En=1 -> Err_Cnt saturates at 15 and holds. Err_Clr on a cycle whose word has e>0 -> Err_Cnt=0, Err_Flag=0 next cycle.
6. DW=8, PP=58 -> Sync_o rises on the 8th accept (NW=8). Assert Rs after 100 words -> Sync_o=0 and H=SI; Sync_o reasserts after 8 more accepts and loopback data is zero again.
